// File: rtl/wishbone_byte_stream_loader.sv
// wishbone_byte_stream_loader
// Boot-time Wishbone B3 master: packs a valid/ready byte stream big-endian into 32-bit
// words (first byte -> dat[31:24]/sel[3]) and writes each word with one classic cycle.
// Optional feature: define LOADER_READBACK_VERIFY_EN to read every word back after its
// write and compare the written lanes; otherwise wb_dat_i is unused.
module wishbone_byte_stream_loader #(
  parameter int          ADR_WIDTH = 11,
  parameter logic [31:0] BASE_ADR  = 32'h0
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 start_i,
  input  logic [7:0]           byte_i,
  input  logic                 byte_valid_i,
  output logic                 byte_ready_o,
  input  logic                 flush_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [ADR_WIDTH+2:0] byte_count_o,
  output logic [31:0]          wb_adr_o,
  output logic [31:0]          wb_dat_o,
  output logic [3:0]           wb_sel_o,
  output logic                 wb_we_o,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  input  logic [31:0]          wb_dat_i,
  input  logic                 wb_ack_i,
  input  logic                 wb_err_i
);

  localparam int            CW       = ADR_WIDTH + 3;
  localparam logic [CW-1:0] CAPACITY = CW'(4) << ADR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
`ifdef LOADER_READBACK_VERIFY_EN
    S_GAP,
    S_VERIFY,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [1:0]      r_lane;
  logic [1:0]      w_nextLane;
  logic [31:0]     r_data;
  logic [31:0]     w_nextData;
  logic [3:0]      r_sel;
  logic [3:0]      w_nextSel;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_nextCount;
  logic [31:0]     r_adr;
  logic [31:0]     w_nextAdr;
  logic            r_flushPend;
  logic            w_nextFlushPend;
  logic            r_cyc;
  logic            r_we;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic            r_ready;
  logic            w_full;

  assign w_full = (r_count == CAPACITY);

`ifdef LOADER_READBACK_VERIFY_EN
  logic [3:0]  r_busSel;
  logic [31:0] w_laneMask;
  logic        w_readBad;

  assign w_laneMask = {{8{r_sel[3]}}, {8{r_sel[2]}}, {8{r_sel[1]}}, {8{r_sel[0]}}};
  assign w_readBad  = |((wb_dat_i ^ r_data) & w_laneMask);
  assign wb_sel_o   = r_busSel;
`else
  logic w_unusedDat;

  assign w_unusedDat = ^wb_dat_i;
  assign wb_sel_o    = r_sel;
`endif

  assign byte_ready_o = r_ready;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign err_o        = r_err;
  assign byte_count_o = r_count;
  assign wb_adr_o     = r_adr;
  assign wb_dat_o     = r_data;
  assign wb_we_o      = r_we;
  assign wb_cyc_o     = r_cyc;
  assign wb_stb_o     = r_cyc;

  // Next-state and next-datapath decisions: packing, flush handling, bus responses.
  always_comb begin
    w_nextState     = r_state;
    w_nextLane      = r_lane;
    w_nextData      = r_data;
    w_nextSel       = r_sel;
    w_nextCount     = r_count;
    w_nextAdr       = r_adr;
    w_nextFlushPend = r_flushPend;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          w_nextState     = S_COLLECT;
          w_nextLane      = 2'd0;
          w_nextData      = '0;
          w_nextSel       = '0;
          w_nextCount     = '0;
          w_nextAdr       = BASE_ADR;
          w_nextFlushPend = 1'b0;
        end
      end
      S_COLLECT: begin
        if (byte_valid_i && w_full) begin
          w_nextState = S_ERROR;
        end else begin
          if (byte_valid_i) begin
            w_nextCount = r_count + CW'(1);
            w_nextLane  = r_lane + 2'd1;
            unique case (r_lane)
              2'd0: begin w_nextData[31:24] = byte_i; w_nextSel[3] = 1'b1; end
              2'd1: begin w_nextData[23:16] = byte_i; w_nextSel[2] = 1'b1; end
              2'd2: begin w_nextData[15:8]  = byte_i; w_nextSel[1] = 1'b1; end
              2'd3: begin w_nextData[7:0]   = byte_i; w_nextSel[0] = 1'b1; end
            endcase
          end
          if (byte_valid_i && (r_lane == 2'd3)) begin
            w_nextState     = S_WRITE;
            w_nextFlushPend = flush_i;
          end else if (flush_i) begin
            if (byte_valid_i || (r_lane != 2'd0)) begin
              w_nextState     = S_WRITE;
              w_nextFlushPend = 1'b1;
            end else begin
              w_nextState = S_DONE;
            end
          end
        end
      end
      S_WRITE: begin
        if (wb_err_i) begin
          w_nextState = S_ERROR;
        end else if (wb_ack_i) begin
`ifdef LOADER_READBACK_VERIFY_EN
          w_nextState = S_GAP;
`else
          w_nextAdr   = r_adr + 32'd4;
          w_nextData  = '0;
          w_nextSel   = '0;
          w_nextState = r_flushPend ? S_DONE : S_COLLECT;
`endif
        end
      end
`ifdef LOADER_READBACK_VERIFY_EN
      S_GAP: begin
        w_nextState = S_VERIFY;
      end
      S_VERIFY: begin
        if (wb_err_i) begin
          w_nextState = S_ERROR;
        end else if (wb_ack_i) begin
          if (w_readBad) begin
            w_nextState = S_ERROR;
          end else begin
            w_nextAdr   = r_adr + 32'd4;
            w_nextData  = '0;
            w_nextSel   = '0;
            w_nextState = r_flushPend ? S_DONE : S_COLLECT;
          end
        end
      end
`endif
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Datapath and registered bus/status outputs, all derived from the next state.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_lane      <= 2'd0;
      r_data      <= '0;
      r_sel       <= '0;
      r_count     <= '0;
      r_adr       <= '0;
      r_flushPend <= 1'b0;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_ready     <= 1'b0;
`ifdef LOADER_READBACK_VERIFY_EN
      r_busSel    <= '0;
`endif
    end else begin
      r_lane      <= w_nextLane;
      r_data      <= w_nextData;
      r_sel       <= w_nextSel;
      r_count     <= w_nextCount;
      r_adr       <= w_nextAdr;
      r_flushPend <= w_nextFlushPend;
      r_we        <= (w_nextState == S_WRITE);
      r_busy      <= !(w_nextState inside {S_IDLE, S_DONE, S_ERROR});
      r_done      <= (w_nextState == S_DONE);
      r_err       <= (w_nextState == S_ERROR);
      r_ready     <= (w_nextState == S_COLLECT) && (w_nextCount != CAPACITY);
`ifdef LOADER_READBACK_VERIFY_EN
      r_cyc       <= (w_nextState == S_WRITE) || (w_nextState == S_VERIFY);
      r_busSel    <= (w_nextState == S_VERIFY) ? 4'hF : w_nextSel;
`else
      r_cyc       <= (w_nextState == S_WRITE);
`endif
    end
  end

endmodule

// File: tb/tb_wishbone_byte_stream_loader.sv
// tb_wishbone_byte_stream_loader
// Directed bench: table of stream vectors plus hand-written corner sequences, with a
// small Wishbone RAM slave model that logs every write cycle it acknowledges.
`timescale 1ns/1ps
module tb_wishbone_byte_stream_loader;

  localparam int          ADR_WIDTH = 2;
  localparam logic [31:0] BASE      = 32'h0000_0100;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [7:0]           byteData = 8'h00;
  logic                 byteValid = 1'b0;
  logic                 byteReady;
  logic                 flush = 1'b0;
  logic                 busy, done, err;
  logic [ADR_WIDTH+2:0] count;
  logic [31:0]          wbAdr, wbDatO;
  logic [3:0]           wbSel;
  logic                 wbWe, wbCyc, wbStb;
  logic [31:0]          slvRdata = 32'h0;
  logic                 slvAck = 1'b0;
  logic                 slvErr = 1'b0;

  int          slvWait = 0;
  bit          errArm = 1'b0;
  logic [31:0] corrupt = 32'h0;
  int          waitCnt = 0;
  int          stabViol = 0;
  bit          prevActive = 1'b0;
  logic [31:0] prevAdr = 32'h0, prevDat = 32'h0;
  logic [3:0]  prevSel = 4'h0;
  logic        prevWe = 1'b0;
  logic [31:0] mem [logic [31:0]];

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wr_t;
  wr_t logQ[$];

  typedef struct {
    int          nBytes;
    logic [7:0]  first;
    int          gap;
    int          nWords;
    logic [31:0] dat0;
    logic [3:0]  sel0;
    logic [31:0] dat1;
    logic [3:0]  sel1;
  } vec_t;
  vec_t vecs [6];

  int nCompared = 0;
  int nMismatched = 0;

  wishbone_byte_stream_loader #(.ADR_WIDTH(ADR_WIDTH), .BASE_ADR(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .byte_i(byteData),
    .byte_valid_i(byteValid), .byte_ready_o(byteReady), .flush_i(flush),
    .busy_o(busy), .done_o(done), .err_o(err), .byte_count_o(count),
    .wb_adr_o(wbAdr), .wb_dat_o(wbDatO), .wb_sel_o(wbSel), .wb_we_o(wbWe),
    .wb_cyc_o(wbCyc), .wb_stb_o(wbStb), .wb_dat_i(slvRdata),
    .wb_ack_i(slvAck), .wb_err_i(slvErr)
  );

  always #5 clk = ~clk;

  // RAM slave: single-cycle ack/err after slvWait wait states, logs writes, serves reads.
  always @(posedge clk) begin
    if (rst) begin
      slvAck  <= 1'b0;
      slvErr  <= 1'b0;
      waitCnt <= 0;
    end else if (slvAck || slvErr) begin
      slvAck  <= 1'b0;
      slvErr  <= 1'b0;
      waitCnt <= 0;
    end else if (wbCyc && wbStb) begin
      if (waitCnt >= slvWait) begin
        if (wbWe) begin
          logQ.push_back('{wbAdr, wbDatO, wbSel});
          if (errArm) begin
            slvErr <= 1'b1;
          end else begin
            mem[wbAdr] = wbDatO;
            slvAck <= 1'b1;
          end
        end else begin
          slvRdata <= (mem.exists(wbAdr) ? mem[wbAdr] : 32'h0) ^ corrupt;
          slvAck   <= 1'b1;
        end
      end else begin
        waitCnt <= waitCnt + 1;
      end
    end else begin
      waitCnt <= 0;
    end
  end

  // Bus-hold watcher: address, data, lanes and direction must not move within a cycle.
  always @(posedge clk) begin
    if (wbCyc && wbStb) begin
      if (prevActive && (wbAdr != prevAdr || wbDatO != prevDat || wbSel != prevSel || wbWe != prevWe))
        stabViol <= stabViol + 1;
      prevActive <= 1'b1;
      prevAdr    <= wbAdr;
      prevDat    <= wbDatO;
      prevSel    <= wbSel;
      prevWe     <= wbWe;
    end else begin
      prevActive <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit withFlush, output bit ok);
    int t = 0;
    ok = 1'b0;
    byteData  = b;
    byteValid = 1'b1;
    flush     = withFlush;
    while (!ok && t < 100) begin
      if (byteReady) ok = 1'b1;
      @(negedge clk);
      t++;
    end
    byteValid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic sendFlush(input string name);
    int t = 0;
    while (!byteReady && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!byteReady) checkOutput({name, " flush ready timeout"}, 32'd0, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic waitEnd(input string name);
    int t = 0;
    while (!(done || err) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!(done || err)) checkOutput({name, " end timeout"}, 32'd0, 32'd1);
  endtask

  task automatic sendRun(input string name, input logic [7:0] first, input int n, input int gap);
    bit ok;
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = first + 8'(i);
      sendByte(b, 1'b0, ok);
      if (!ok) checkOutput($sformatf("%s byte%0d timeout", name, i), 32'd0, 32'd1);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic checkWord(input string name, input int k, input logic [31:0] dat, input logic [3:0] sel);
    if (k >= logQ.size()) begin
      checkOutput($sformatf("%s word%0d present", name, k), 32'(logQ.size()), 32'(k + 1));
    end else begin
      checkOutput($sformatf("%s word%0d adr", name, k), logQ[k].adr, BASE + 32'(4 * k));
      checkOutput($sformatf("%s word%0d dat", name, k), logQ[k].dat, dat);
      checkOutput($sformatf("%s word%0d sel", name, k), 32'(logQ[k].sel), 32'(sel));
    end
  endtask

  task automatic checkEnd(input string name, input bit expDone, input int expCount);
    checkOutput({name, " done"}, 32'(done), 32'(expDone));
    checkOutput({name, " err"}, 32'(err), 32'(!expDone));
    checkOutput({name, " busy"}, 32'(busy), 32'd0);
    checkOutput({name, " ready"}, 32'(byteReady), 32'd0);
    checkOutput({name, " count"}, 32'(count), 32'(expCount));
  endtask

  task automatic applyStimulus(input int v);
    string name;
    name = $sformatf("vec%0d", v);
    logQ.delete();
    pulseStart();
    sendRun(name, vecs[v].first, vecs[v].nBytes, vecs[v].gap);
    sendFlush(name);
    waitEnd(name);
    checkOutput({name, " words"}, 32'(logQ.size()), 32'(vecs[v].nWords));
    if (vecs[v].nWords > 0) checkWord(name, 0, vecs[v].dat0, vecs[v].sel0);
    if (vecs[v].nWords > 1) checkWord(name, 1, vecs[v].dat1, vecs[v].sel1);
    checkEnd(name, 1'b1, vecs[v].nBytes);
  endtask

  initial begin
    bit ok;
    int t;
    logic [7:0] b;
    logic [31:0] w;

    vecs[0] = '{8, 8'h00, 0, 2, 32'h00010203, 4'hF, 32'h04050607, 4'hF};
    vecs[1] = '{6, 8'hAA, 1, 2, 32'hAAABACAD, 4'hF, 32'hAEAF0000, 4'hC};
    vecs[2] = '{3, 8'h10, 0, 1, 32'h10111200, 4'hE, 32'h0, 4'h0};
    vecs[3] = '{4, 8'h20, 2, 1, 32'h20212223, 4'hF, 32'h0, 4'h0};
    vecs[4] = '{0, 8'h00, 0, 0, 32'h0, 4'h0, 32'h0, 4'h0};
    vecs[5] = '{1, 8'h55, 0, 1, 32'h55000000, 4'h8, 32'h0, 4'h0};

    repeat (3) @(negedge clk);
    checkOutput("reset cyc", 32'(wbCyc), 32'd0);
    checkOutput("reset stb", 32'(wbStb), 32'd0);
    checkOutput("reset we", 32'(wbWe), 32'd0);
    checkOutput("reset adr", wbAdr, 32'h0);
    checkOutput("reset dat", wbDatO, 32'h0);
    checkOutput("reset sel", 32'(wbSel), 32'd0);
    checkOutput("reset status", {28'd0, busy, done, err, byteReady}, 32'd0);
    checkOutput("reset count", 32'(count), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle busy", 32'(busy), 32'd0);

    $display("[TB] table vectors");
    for (int v = 0; v < 6; v++) applyStimulus(v);

    $display("[TB] byte and flush in the same cycle");
    logQ.delete();
    pulseStart();
    sendRun("bf3", 8'h70, 2, 0);
    sendByte(8'h72, 1'b1, ok);
    checkOutput("bf3 accepted", 32'(ok), 32'd1);
    waitEnd("bf3");
    checkOutput("bf3 words", 32'(logQ.size()), 32'd1);
    checkWord("bf3", 0, 32'h70717200, 4'hE);
    checkEnd("bf3", 1'b1, 3);

    logQ.delete();
    pulseStart();
    sendRun("bf4", 8'h80, 3, 0);
    sendByte(8'h83, 1'b1, ok);
    checkOutput("bf4 accepted", 32'(ok), 32'd1);
    waitEnd("bf4");
    checkOutput("bf4 words", 32'(logQ.size()), 32'd1);
    checkWord("bf4", 0, 32'h80818283, 4'hF);
    checkEnd("bf4", 1'b1, 4);

    $display("[TB] stalled ack, valid gaps, ignored restart");
    slvWait = 5;
    logQ.delete();
    pulseStart();
    for (int i = 0; i < 8; i++) begin
      b = 8'h60 + 8'(i);
      sendByte(b, 1'b0, ok);
      if (!ok) checkOutput($sformatf("stall byte%0d timeout", i), 32'd0, 32'd1);
      if (i == 2) pulseStart();
      repeat (i % 3) @(negedge clk);
    end
    sendFlush("stall");
    waitEnd("stall");
    checkOutput("stall words", 32'(logQ.size()), 32'd2);
    checkWord("stall", 0, 32'h60616263, 4'hF);
    checkWord("stall", 1, 32'h64656667, 4'hF);
    checkEnd("stall", 1'b1, 8);
    slvWait = 0;

    $display("[TB] bus error on first write");
    errArm = 1'b1;
    pulseStart();
    sendRun("berr", 8'h01, 4, 0);
    waitEnd("berr");
    checkOutput("berr cyc", 32'(wbCyc), 32'd0);
    checkOutput("berr stb", 32'(wbStb), 32'd0);
    checkEnd("berr", 1'b0, 4);
    errArm = 1'b0;

    $display("[TB] overflow");
    logQ.delete();
    pulseStart();
    sendRun("ovf", 8'h30, 16, 0);
    byteData  = 8'hEE;
    byteValid = 1'b1;
    t = 0;
    while (!err && t < 50) begin
      @(negedge clk);
      t++;
    end
    byteValid = 1'b0;
    checkOutput("ovf words", 32'(logQ.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      b = 8'h30 + 8'(4 * k);
      w = {b, b + 8'd1, b + 8'd2, b + 8'd3};
      checkWord("ovf", k, w, 4'hF);
    end
    checkEnd("ovf", 1'b0, 16);

    $display("[TB] corrupted readback");
    corrupt = 32'h0000_0100;
    logQ.delete();
    pulseStart();
    sendRun("rbk", 8'hC0, 4, 0);
    sendFlush("rbk");
    waitEnd("rbk");
`ifdef LOADER_READBACK_VERIFY_EN
    checkEnd("rbk", 1'b0, 4);
`else
    checkEnd("rbk", 1'b1, 4);
`endif
    corrupt = 32'h0;

    $display("[TB] reset during a write cycle");
    slvWait = 5;
    pulseStart();
    sendRun("rmid", 8'h90, 4, 0);
    t = 0;
    while (!wbCyc && t < 20) begin
      @(negedge clk);
      t++;
    end
    checkOutput("rmid cyc before", 32'(wbCyc), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rmid cyc", 32'(wbCyc), 32'd0);
    checkOutput("rmid stb", 32'(wbStb), 32'd0);
    checkOutput("rmid busy", 32'(busy), 32'd0);
    checkOutput("rmid count", 32'(count), 32'd0);
    checkOutput("rmid adr", wbAdr, 32'h0);
    slvWait = 0;
    repeat (3) @(negedge clk);

    checkOutput("bus hold violations", 32'(stabViol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
